// File: rtl/key_lookup_sched_pkg.sv
// Shared configuration, key record layout and round-robin helper for the
// key lookup scheduler.
package key_lookup_sched_pkg;

  localparam int REQ_NUM         = 5;
  localparam int PORT_NUM        = 4;
  localparam int HASH_DATA_WIDTH = 12;
  localparam int OUTSTANDING_MAX = 8;
  localparam int MAC_W           = 48;
  localparam int REQ_ID_W        = $clog2(REQ_NUM);
  localparam int CNT_W           = $clog2(OUTSTANDING_MAX) + 1;

  // Held key record, LSB first: dmac hash, dmac, smac hash, smac
  localparam int DHASH_LSB = 0;
  localparam int DMAC_LSB  = DHASH_LSB + HASH_DATA_WIDTH;
  localparam int SHASH_LSB = DMAC_LSB + MAC_W;
  localparam int SMAC_LSB  = SHASH_LSB + HASH_DATA_WIDTH;
  localparam int KEY_W     = SMAC_LSB + MAC_W;

  typedef logic [REQ_ID_W-1:0] req_id_t;
  typedef logic [KEY_W-1:0]    key_rec_t;

  function automatic req_id_t rr_next(input req_id_t id);
    return (id == req_id_t'(REQ_NUM - 1)) ? '0 : id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/key_tag_fifo.sv
// Synchronous tag FIFO holding the requester ID of every lookup in flight,
// in issue order. Push while full is accepted only when a pop happens too.
module key_tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_lookup_sched.sv
// Shares one MAC-table lookup engine between REQ_NUM key sources: one-deep
// hold buffer per requester, round-robin issue, in-order result routing.
module key_lookup_sched
  import key_lookup_sched_pkg::*;
(
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [REQ_NUM-1:0]                  i_key_vld,
  output logic [REQ_NUM-1:0]                  o_key_rdy,
  input  logic [REQ_NUM*HASH_DATA_WIDTH-1:0]  i_dmac_hash_key,
  input  logic [REQ_NUM*MAC_W-1:0]            i_dmac,
  input  logic [REQ_NUM*HASH_DATA_WIDTH-1:0]  i_smac_hash_key,
  input  logic [REQ_NUM*MAC_W-1:0]            i_smac,
  output logic [REQ_NUM-1:0]                  o_dmac_port,
  output logic [HASH_DATA_WIDTH-1:0]          o_dmac_hash_key,
  output logic [MAC_W-1:0]                    o_dmac,
  output logic [HASH_DATA_WIDTH-1:0]          o_smac_hash_key,
  output logic [MAC_W-1:0]                    o_smac,
  output logic                                o_lkp_vld,
  input  logic                                i_lkp_rdy,
  input  logic [PORT_NUM-1:0]                 i_tx_port,
  input  logic                                i_tx_port_vld,
  output logic [REQ_NUM*PORT_NUM-1:0]         o_rsp_port,
  output logic [REQ_NUM-1:0]                  o_rsp_vld,
  output logic [CNT_W-1:0]                    o_inflight,
  output logic                                o_err_unexp
);

  // Handshakes: a key moves when i_key_vld[r] & o_key_rdy[r] at a clock edge.
  // A lookup is committed when i_lkp_rdy is high in the decision cycle; the
  // registered o_lkp_vld pulse follows one cycle later and is not held.
  // Results carry no tag and always belong to the oldest outstanding lookup.

  logic [REQ_NUM-1:0] hold_vld;
  key_rec_t           hold_key [REQ_NUM];
  req_id_t            rr_ptr;
  req_id_t            win;
  req_id_t            cand;
  logic               found;
  logic [REQ_NUM-1:0] win_onehot;
  logic               issue;
  logic               fifo_full;
  logic               fifo_empty;
  logic               tag_pop;
  req_id_t            tag_head;
  logic [REQ_NUM-1:0]          rsp_vld_next;
  logic [REQ_NUM*PORT_NUM-1:0] rsp_port_next;

  assign o_key_rdy = ~hold_vld;
  assign tag_pop   = i_tx_port_vld & ~fifo_empty;
  assign issue     = (|hold_vld) & i_lkp_rdy & (~fifo_full | tag_pop);

  // Round-robin search starting at rr_ptr
  always_comb begin
    win        = rr_ptr;
    cand       = rr_ptr;
    found      = 1'b0;
    win_onehot = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (!found && hold_vld[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = rr_next(cand);
    end
    win_onehot[win] = 1'b1;
  end

  always_comb begin
    rsp_vld_next  = '0;
    rsp_port_next = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (tag_pop && tag_head == req_id_t'(r)) begin
        rsp_vld_next[r] = 1'b1;
        rsp_port_next[r*PORT_NUM +: PORT_NUM] = i_tx_port;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_vld <= '0;
      for (int r = 0; r < REQ_NUM; r++) hold_key[r] <= '0;
    end else begin
      for (int r = 0; r < REQ_NUM; r++) begin
        if (i_key_vld[r] && !hold_vld[r]) begin
          hold_vld[r] <= 1'b1;
          hold_key[r] <= {i_smac[r*MAC_W +: MAC_W],
                          i_smac_hash_key[r*HASH_DATA_WIDTH +: HASH_DATA_WIDTH],
                          i_dmac[r*MAC_W +: MAC_W],
                          i_dmac_hash_key[r*HASH_DATA_WIDTH +: HASH_DATA_WIDTH]};
        end else if (issue && win == req_id_t'(r)) begin
          hold_vld[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr          <= '0;
      o_lkp_vld       <= 1'b0;
      o_dmac_port     <= '0;
      o_dmac_hash_key <= '0;
      o_dmac          <= '0;
      o_smac_hash_key <= '0;
      o_smac          <= '0;
    end else begin
      o_lkp_vld   <= issue;
      o_dmac_port <= issue ? win_onehot : '0;
      if (issue) begin
        rr_ptr          <= rr_next(win);
        o_dmac_hash_key <= hold_key[win][DHASH_LSB +: HASH_DATA_WIDTH];
        o_dmac          <= hold_key[win][DMAC_LSB  +: MAC_W];
        o_smac_hash_key <= hold_key[win][SHASH_LSB +: HASH_DATA_WIDTH];
        o_smac          <= hold_key[win][SMAC_LSB  +: MAC_W];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rsp_vld   <= '0;
      o_rsp_port  <= '0;
      o_err_unexp <= 1'b0;
    end else begin
      o_rsp_vld  <= rsp_vld_next;
      o_rsp_port <= rsp_port_next;
      if (i_tx_port_vld && fifo_empty) o_err_unexp <= 1'b1;
    end
  end

  key_tag_fifo #(
    .WIDTH (REQ_ID_W),
    .DEPTH (OUTSTANDING_MAX)
  ) u_tag_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (issue),
    .push_data (win),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_inflight)
  );

endmodule

// File: tb/tb_key_lookup_sched.sv
// Bench for key_lookup_sched: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_key_lookup_sched;
  import key_lookup_sched_pkg::*;

  localparam int H = HASH_DATA_WIDTH;

  logic                          i_clk = 1'b0;
  logic                          i_rst;
  logic [REQ_NUM-1:0]            i_key_vld;
  logic [REQ_NUM-1:0]            o_key_rdy;
  logic [REQ_NUM*H-1:0]          i_dmac_hash_key;
  logic [REQ_NUM*MAC_W-1:0]      i_dmac;
  logic [REQ_NUM*H-1:0]          i_smac_hash_key;
  logic [REQ_NUM*MAC_W-1:0]      i_smac;
  logic [REQ_NUM-1:0]            o_dmac_port;
  logic [H-1:0]                  o_dmac_hash_key;
  logic [MAC_W-1:0]              o_dmac;
  logic [H-1:0]                  o_smac_hash_key;
  logic [MAC_W-1:0]              o_smac;
  logic                          o_lkp_vld;
  logic                          i_lkp_rdy;
  logic [PORT_NUM-1:0]           i_tx_port;
  logic                          i_tx_port_vld;
  logic [REQ_NUM*PORT_NUM-1:0]   o_rsp_port;
  logic [REQ_NUM-1:0]            o_rsp_vld;
  logic [CNT_W-1:0]              o_inflight;
  logic                          o_err_unexp;

  key_lookup_sched dut (
    .i_clk (i_clk), .i_rst (i_rst),
    .i_key_vld (i_key_vld), .o_key_rdy (o_key_rdy),
    .i_dmac_hash_key (i_dmac_hash_key), .i_dmac (i_dmac),
    .i_smac_hash_key (i_smac_hash_key), .i_smac (i_smac),
    .o_dmac_port (o_dmac_port), .o_dmac_hash_key (o_dmac_hash_key), .o_dmac (o_dmac),
    .o_smac_hash_key (o_smac_hash_key), .o_smac (o_smac),
    .o_lkp_vld (o_lkp_vld), .i_lkp_rdy (i_lkp_rdy),
    .i_tx_port (i_tx_port), .i_tx_port_vld (i_tx_port_vld),
    .o_rsp_port (o_rsp_port), .o_rsp_vld (o_rsp_vld),
    .o_inflight (o_inflight), .o_err_unexp (o_err_unexp)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Reference model state
  bit                         pend [REQ_NUM];
  logic [H-1:0]               p_dh [REQ_NUM];
  logic [MAC_W-1:0]           p_dm [REQ_NUM];
  logic [H-1:0]               p_sh [REQ_NUM];
  logic [MAC_W-1:0]           p_sm [REQ_NUM];
  int                         rr;
  logic [REQ_ID_W-1:0]        exp_q [$];
  logic                       e_lkp_vld;
  logic [REQ_NUM-1:0]         e_port;
  logic [H-1:0]               e_dh, e_sh;
  logic [MAC_W-1:0]           e_dm, e_sm;
  logic [REQ_NUM-1:0]         e_rsp_vld;
  logic [REQ_NUM*PORT_NUM-1:0] e_rsp_port;
  logic                       e_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < REQ_NUM; r++) pend[r] = 0;
    rr = 0;
    exp_q.delete();
    e_lkp_vld = 0; e_port = '0;
    e_dh = '0; e_dm = '0; e_sh = '0; e_sm = '0;
    e_rsp_vld = '0; e_rsp_port = '0; e_err = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit pop, can, was_empty;
    int w;
    logic [REQ_ID_W-1:0] id;
    logic [REQ_NUM*PORT_NUM-1:0] tmp;
    if (i_rst) begin
      model_reset();
      return;
    end
    w = 0;
    was_empty = (exp_q.size() == 0);
    pop = i_tx_port_vld && !was_empty;
    can = 0;
    if (i_lkp_rdy && (exp_q.size() < OUTSTANDING_MAX || pop))
      for (int k = 0; k < REQ_NUM; k++)
        if (!can && pend[(rr + k) % REQ_NUM]) begin
          can = 1;
          w = (rr + k) % REQ_NUM;
        end
    e_lkp_vld = can;
    e_port = '0;
    if (can) begin
      e_port[w] = 1'b1;
      e_dh = p_dh[w]; e_dm = p_dm[w]; e_sh = p_sh[w]; e_sm = p_sm[w];
    end
    e_rsp_vld = '0;
    e_rsp_port = '0;
    if (pop) begin
      id = exp_q.pop_front();
      e_rsp_vld[id] = 1'b1;
      tmp = '0;
      tmp[PORT_NUM-1:0] = i_tx_port;
      e_rsp_port = tmp << (int'(id) * PORT_NUM);
    end
    if (i_tx_port_vld && was_empty) e_err = 1;
    for (int r = 0; r < REQ_NUM; r++)
      if (i_key_vld[r] && !pend[r]) begin
        pend[r] = 1;
        p_dh[r] = i_dmac_hash_key[r*H +: H];
        p_dm[r] = i_dmac[r*MAC_W +: MAC_W];
        p_sh[r] = i_smac_hash_key[r*H +: H];
        p_sm[r] = i_smac[r*MAC_W +: MAC_W];
      end
    if (can) begin
      exp_q.push_back(REQ_ID_W'(w));
      pend[w] = 0;
      rr = (w + 1) % REQ_NUM;
    end
  endtask

  task automatic check_all();
    logic [REQ_NUM-1:0] e_rdy;
    for (int r = 0; r < REQ_NUM; r++) e_rdy[r] = !pend[r];
    chk("key_rdy", o_key_rdy, e_rdy);
    chk("lkp_vld", o_lkp_vld, e_lkp_vld);
    chk("dmac_port", o_dmac_port, e_port);
    if (e_lkp_vld) begin
      chk("dmac_hash_key", o_dmac_hash_key, e_dh);
      chk("dmac", o_dmac, e_dm);
      chk("smac_hash_key", o_smac_hash_key, e_sh);
      chk("smac", o_smac, e_sm);
    end
    chk("rsp_vld", o_rsp_vld, e_rsp_vld);
    chk("rsp_port", o_rsp_port, e_rsp_port);
    chk("inflight", o_inflight, exp_q.size());
    chk("err_unexp", o_err_unexp, e_err);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge
  task automatic tick();
    model_step();
    @(negedge i_clk);
    check_all();
  endtask

  // Driver tasks
  task automatic set_idle();
    i_key_vld = '0; i_lkp_rdy = 0; i_tx_port_vld = 0; i_tx_port = '0;
  endtask

  task automatic randomize_keys();
    for (int r = 0; r < REQ_NUM; r++) begin
      i_dmac_hash_key[r*H +: H] = H'($urandom);
      i_smac_hash_key[r*H +: H] = H'($urandom);
      i_dmac[r*MAC_W +: MAC_W] = {16'($urandom), $urandom};
      i_smac[r*MAC_W +: MAC_W] = {16'($urandom), $urandom};
    end
  endtask

  task automatic do_reset();
    set_idle();
    i_rst = 1;
    tick();
    tick();
    i_rst = 0;
  endtask

  int g [$];
  int exp_g [7] = '{0, 1, 2, 3, 4, 0, 1};

  initial begin
    i_rst = 1;
    set_idle();
    randomize_keys();
    model_reset();
    @(negedge i_clk);
    check_all();
    chk("rst_key_rdy", o_key_rdy, 5'h1f);
    chk("rst_inflight", o_inflight, 0);
    chk("rst_lkp_vld", o_lkp_vld, 0);
    chk("rst_rsp_vld", o_rsp_vld, 0);
    tick();
    i_rst = 0;

    // Single key from requester 2 and its result
    set_idle();
    i_lkp_rdy = 1;
    i_dmac[2*MAC_W +: MAC_W] = 48'h0a0b_0c0d_0e02;
    i_key_vld = 5'b00100;
    tick();
    i_key_vld = '0;
    tick();
    chk("t1_lkp_vld", o_lkp_vld, 1);
    chk("t1_port", o_dmac_port, 5'b00100);
    chk("t1_dmac", o_dmac, 48'h0a0b_0c0d_0e02);
    chk("t1_inflight", o_inflight, 1);
    i_tx_port_vld = 1;
    i_tx_port = 4'b0010;
    tick();
    i_tx_port_vld = 0;
    chk("t1_rsp_vld", o_rsp_vld, 5'b00100);
    chk("t1_rsp_port", o_rsp_port, 20'h00200);
    chk("t1_inflight0", o_inflight, 0);
    chk("t1_lkp_pulse", o_lkp_vld, 0);

    // All requesters valid every cycle: strict rotation
    do_reset();
    i_lkp_rdy = 1;
    i_key_vld = '1;
    repeat (8) begin
      randomize_keys();
      tick();
      if (o_lkp_vld)
        for (int r = 0; r < REQ_NUM; r++) if (o_dmac_port[r]) g.push_back(r);
    end
    chk("t2_ngrants", g.size(), 7);
    for (int i = 0; i < 7 && i < g.size(); i++) chk("t2_grant", g[i], exp_g[i]);

    // Engine not ready: nothing issues, buffers stay full
    do_reset();
    i_key_vld = '1;
    tick();
    repeat (10) begin
      tick();
      chk("t3_lkp_vld", o_lkp_vld, 0);
      chk("t3_key_rdy", o_key_rdy, 0);
    end
    i_lkp_rdy = 1;
    tick();
    tick();
    chk("t3_resume", o_lkp_vld, 1);

    // Fill the tag FIFO, stall, then issue on the cycle a result pops
    do_reset();
    i_key_vld = '1;
    i_lkp_rdy = 1;
    repeat (9) tick();
    chk("t4_inflight8", o_inflight, 8);
    repeat (2) begin
      tick();
      chk("t4_stall", o_lkp_vld, 0);
      chk("t4_stall_inflight", o_inflight, 8);
    end
    i_tx_port_vld = 1;
    i_tx_port = 4'b1001;
    tick();
    i_tx_port_vld = 0;
    chk("t4_issue_on_pop", o_lkp_vld, 1);
    chk("t4_inflight_hold", o_inflight, 8);
    chk("t4_rsp_vld", o_rsp_vld, 5'b00001);
    chk("t4_rsp_port", o_rsp_port, 20'h00009);

    // Result with nothing outstanding
    do_reset();
    i_tx_port_vld = 1;
    i_tx_port = 4'hf;
    tick();
    i_tx_port_vld = 0;
    chk("t5_rsp_vld", o_rsp_vld, 0);
    chk("t5_err", o_err_unexp, 1);
    repeat (5) tick();
    chk("t5_err_sticky", o_err_unexp, 1);

    // Asynchronous reset with three lookups in flight
    do_reset();
    i_key_vld = 5'b00111;
    i_lkp_rdy = 1;
    tick();
    i_key_vld = '0;
    repeat (3) tick();
    chk("t6_inflight3", o_inflight, 3);
    #2 i_rst = 1;
    #1;
    chk("t6_async_inflight", o_inflight, 0);
    chk("t6_async_key_rdy", o_key_rdy, 5'h1f);
    chk("t6_async_lkp_vld", o_lkp_vld, 0);
    chk("t6_async_port", o_dmac_port, 0);
    model_reset();
    @(negedge i_clk);
    check_all();
    i_rst = 0;
    set_idle();
    i_tx_port_vld = 1;
    tick();
    i_tx_port_vld = 0;
    chk("t6_err_after_rst", o_err_unexp, 1);

    // Random traffic
    do_reset();
    repeat (3000) begin
      i_rst = ($urandom_range(0, 399) == 0);
      i_key_vld = REQ_NUM'($urandom_range(0, (1 << REQ_NUM) - 1));
      randomize_keys();
      i_lkp_rdy = ($urandom_range(0, 3) != 0);
      i_tx_port = PORT_NUM'($urandom);
      i_tx_port_vld = (exp_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                         : ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
